// File: rtl/led_panel_pkg.sv
// Shared scan-state encoding, colour bit positions and default panel geometry
// for the LED panel scan path.
package led_panel_pkg;

  localparam int DEF_COLS = 32;
  localparam int DEF_ROWS = 16;
  localparam int DEF_HOLD = 64;

  localparam int ROW_W = $clog2(DEF_ROWS);
  localparam int COL_W = $clog2(DEF_COLS);

  // Bit positions inside the {r,g,b} pixel word coming from the framebuffer.
  localparam int RGB_R = 2;
  localparam int RGB_G = 1;
  localparam int RGB_B = 0;

  typedef enum logic [2:0] {
    ARST,
    FETCH,
    SETUP,
    SCLK,
    LATCH,
    DISPLAY,
    ADVANCE
  } scan_state_t;

endpackage

// File: rtl/led_scan_hold_timer.sv
// Loadable down-counter that paces how long a latched row stays un-blanked.
// It steps once per enabled tick, sticks at zero and flags it.
module led_scan_hold_timer #(
  parameter int W = 7
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/led_scan_ctrl.sv
// Scan sequencer: fetches each row from the framebuffer, shifts it out, latches it,
// shows it for a hold time and steps the panel row counter. Option macro: LED_SCAN_BRIGHT_EN.
module led_scan_ctrl
  import led_panel_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int HOLD_TICKS = DEF_HOLD
) (
  input  logic                                  CLK,
  input  logic                                  rst,
  input  logic                                  tick,
  output logic                                  pix_req,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0]  pix_addr,
  input  logic                                  pix_ack,
  input  logic [2:0]                            pix_rgb,
  output logic                                  red_out,
  output logic                                  green_out,
  output logic                                  blue_out,
  output logic                                  sclk_out,
  output logic                                  latch_out,
  output logic                                  blank_out,
  output logic                                  aclk_out,
  output logic                                  arst_out,
  output logic                                  frame_done
`ifdef LED_SCAN_BRIGHT_EN
  ,
  input  logic [7:0]                            brightness
`endif
);

  localparam int ROW_BITS = $clog2(ROWS);
  localparam int COL_BITS = $clog2(COLS);
`ifdef LED_SCAN_BRIGHT_EN
  localparam int HOLD_W = 8;
`else
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
`endif

  scan_state_t         r_state;
  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col;
  logic                r_arstPend;

  logic [ROW_BITS-1:0] w_rowNext;
  logic [COL_BITS-1:0] w_colNext;
  logic                w_lastRow;
  logic                w_lastCol;
  logic                w_holdLoad;
  logic                w_holdDec;
  logic                w_holdZero;
  logic [HOLD_W-1:0]   w_holdVal;
  logic                w_skipDisplay;

  assign w_rowNext  = r_row + 1'b1;
  assign w_colNext  = r_col + 1'b1;
  assign w_lastRow  = (r_row == ROW_BITS'(ROWS - 1));
  assign w_lastCol  = (r_col == COL_BITS'(COLS - 1));
  assign w_holdLoad = (r_state == LATCH) && tick;
  assign w_holdDec  = (r_state == DISPLAY) && tick;

`ifdef LED_SCAN_BRIGHT_EN
  assign w_holdVal     = brightness - 8'd1;
  assign w_skipDisplay = (brightness == 8'd0);
`else
  assign w_holdVal     = HOLD_W'(HOLD_TICKS - 1);
  assign w_skipDisplay = 1'b0;
`endif

  led_scan_hold_timer #(
    .W(HOLD_W)
  ) u_holdTimer (
    .CLK       (CLK),
    .rst       (rst),
    .i_load    (w_holdLoad),
    .i_loadVal (w_holdVal),
    .i_dec     (w_holdDec),
    .o_zero    (w_holdZero)
  );

  // Outputs are registered alongside the state so they change on the same edge
  // as the transition. latch/aclk/arst/frame_done are one-CLK entry pulses; after
  // a reset the ARST pulse is still owed, so ARST issues it before waiting for tick.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state    <= ARST;
      r_row      <= '0;
      r_col      <= '0;
      r_arstPend <= 1'b1;
      pix_req    <= 1'b0;
      pix_addr   <= '0;
      red_out    <= 1'b0;
      green_out  <= 1'b0;
      blue_out   <= 1'b0;
      sclk_out   <= 1'b0;
      latch_out  <= 1'b0;
      blank_out  <= 1'b1;
      aclk_out   <= 1'b0;
      arst_out   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      latch_out  <= 1'b0;
      aclk_out   <= 1'b0;
      arst_out   <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        ARST: begin
          r_row <= '0;
          r_col <= '0;
          if (r_arstPend) begin
            arst_out   <= 1'b1;
            r_arstPend <= 1'b0;
          end else if (tick) begin
            r_state  <= FETCH;
            pix_req  <= 1'b1;
            pix_addr <= '0;
          end
        end
        FETCH: begin
          if (pix_ack) begin
            red_out   <= pix_rgb[RGB_R];
            green_out <= pix_rgb[RGB_G];
            blue_out  <= pix_rgb[RGB_B];
            pix_req   <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sclk_out <= 1'b1;
            r_state  <= SCLK;
          end
        end
        SCLK: begin
          if (tick) begin
            sclk_out <= 1'b0;
            if (w_lastCol) begin
              r_col     <= '0;
              latch_out <= 1'b1;
              r_state   <= LATCH;
            end else begin
              r_col    <= w_colNext;
              pix_req  <= 1'b1;
              pix_addr <= {r_row, w_colNext};
              r_state  <= FETCH;
            end
          end
        end
        LATCH: begin
          if (tick) begin
            if (w_skipDisplay) begin
              frame_done <= w_lastRow;
              aclk_out   <= !w_lastRow;
              r_state    <= ADVANCE;
            end else begin
              blank_out <= 1'b0;
              r_state   <= DISPLAY;
            end
          end
        end
        DISPLAY: begin
          if (tick && w_holdZero) begin
            blank_out  <= 1'b1;
            frame_done <= w_lastRow;
            aclk_out   <= !w_lastRow;
            r_state    <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (tick) begin
            if (w_lastRow) begin
              r_row    <= '0;
              r_col    <= '0;
              arst_out <= 1'b1;
              r_state  <= ARST;
            end else begin
              r_row    <= w_rowNext;
              pix_req  <= 1'b1;
              pix_addr <= {w_rowNext, {COL_BITS{1'b0}}};
              r_state  <= FETCH;
            end
          end
        end
        default: r_state <= ARST;
      endcase
    end
  end

endmodule
